fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 The module SHALL have no parameters; its only build-time option is the macro in Configuration.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 W_RST  input  1  reset, asynchronous, active-low.
REQ-004 f_enable  input  1  CPU request valid, level-sensitive.
REQ-005 f_write_enable  input  1  1 = write, 0 = read; sampled with f_enable.
REQ-006 addr  input  32  CPU request address.
REQ-007 f_data_i  input  32  CPU write data.
REQ-008 thread  input  2  requesting thread id.
REQ-009 f_data_o  output  32  read data returned to the CPU, registered.
REQ-010 f_ack  output  1  transaction-complete pulse, registered.
REQ-011 W_CLK  input  1  bus cycle qualifier, synchronous to clk and not used as a clock; the bus side advances only on clk edges where W_CLK=1.
REQ-012 W_ACK  input  1  bus slave acknowledge.
REQ-013 W_DATA_I  input  32  bus read data.
REQ-014 W_DATA_O  output  32  bus write data, registered.
REQ-015 W_ADDR  output  32  bus address, registered.
REQ-016 W_WRITE  output  1  bus write strobe, registered.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, REQ and RESP; the encoding is free.
REQ-018 IDLE with f_enable=1 at an edge: latch addr, f_data_i, f_write_enable and thread; drive W_ADDR and W_DATA_O from the latched values; set W_WRITE to the latched write flag; go to REQ.
REQ-019 In REQ, the latched values SHALL be held on the bus; changes to the CPU inputs SHALL have no effect.
REQ-020 REQ with W_CLK=1 and W_ACK=1 at an edge: go to RESP and drop W_WRITE to 0.
REQ-021 The same edge as REQ-020, for a read: load f_data_o from W_DATA_I.
REQ-022 For a write, f_data_o SHALL keep its previous value.
REQ-023 REQ with W_ACK=1 but W_CLK=0: the acknowledge SHALL be ignored and the FSM stays in REQ.
REQ-024 RESP: f_ack=1 for exactly one cycle, then unconditionally go to IDLE; f_ack=0 in every other state.
REQ-025 If f_enable is still 1 when IDLE is re-entered, a new transaction SHALL start; back-to-back requests therefore have one IDLE cycle between them.
REQ-026 Latency: f_enable sampled at edge N, qualified W_ACK at edge M (M ≥ N+1); f_ack is high in the cycle after edge M. The minimum is 2 edges from request to f_ack.
REQ-027 f_enable dropping to 0 while in REQ SHALL NOT abort the transaction; it completes and acks.
REQ-028 W_ADDR and W_DATA_O SHALL hold their last values in IDLE and RESP.
REQ-029 W_WRITE SHALL be 1 only in REQ during a write.
REQ-030 There SHALL be no timeout; REQ waits indefinitely for W_ACK.

Reset
REQ-031 On W_RST=0, the module SHALL immediately, without waiting for clk, enter IDLE and clear f_ack, f_data_o, W_ADDR, W_DATA_O and W_WRITE to 0.
REQ-032 A reset during REQ or RESP SHALL drop the pending transaction with no f_ack.
REQ-033 After W_RST is released, the first possible transaction start SHALL be at the first clk edge.

Configuration
REQ-034 With FETCH_THREAD_BANK_EN defined, W_ADDR = {latched thread, latched addr[29:0]}.
REQ-035 Without FETCH_THREAD_BANK_EN, W_ADDR = latched addr and thread is ignored.

Verification
REQ-036 Read: addr=0x10, f_enable=1, W_CLK=1, W_ACK after 3 cycles with W_DATA_I=0xCAFEBABE -> W_ADDR=0x10 and W_WRITE=0 throughout; single-cycle f_ack; f_data_o=0xCAFEBABE.
REQ-037 Write: addr=0x20, f_data_i=0x12345678, f_write_enable=1 -> W_DATA_O=0x12345678 and W_WRITE=1 until the qualified ack; single-cycle f_ack; f_data_o unchanged.
REQ-038 W_ACK=1 with W_CLK=0 for 4 cycles, then W_CLK=1 -> no f_ack until the W_CLK=1 edge, then exactly one f_ack.
REQ-039 f_enable held at 1 across two reads (0x4, then 0x8 with addr changed after the first ack) -> two f_ack pulses; the second transaction shows W_ADDR=0x8; one IDLE cycle between them.
REQ-040 W_RST=0 asynchronously while in REQ -> all outputs 0 immediately; no f_ack follows.
REQ-041 FETCH_THREAD_BANK_EN defined, thread=2, addr=0x100 -> W_ADDR=0x80000100; without the macro -> W_ADDR=0x100.

Source files
------------

// File: rtl/fetch.sv
// CPU-to-bus fetch/store bridge: one outstanding transaction, IDLE/REQ/RESP handshake.
// Build option: FETCH_THREAD_BANK_EN puts the latched thread id into W_ADDR[31:30].
module fetch (
  input  logic        clk,
  input  logic        W_RST,
  input  logic        f_enable,
  input  logic        f_write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] f_data_i,
  input  logic [1:0]  thread,
  output logic [31:0] f_data_o,
  output logic        f_ack,
  input  logic        W_CLK,
  input  logic        W_ACK,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic [31:0] W_ADDR,
  output logic        W_WRITE
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic        lat_we, lat_we_d;
  logic        f_ack_d, w_write_d;
  logic [31:0] f_data_d, w_addr_d, w_data_d;
  logic [31:0] bus_addr;
  logic        bus_ack;

  // W_CLK only qualifies the edge; the bus side never sees a separate clock.
  assign bus_ack = W_CLK & W_ACK;

`ifdef FETCH_THREAD_BANK_EN
  logic [1:0] unused_addr_hi;
  assign unused_addr_hi = addr[31:30];
  assign bus_addr = {thread, addr[29:0]};
`else
  logic unused_thread;
  assign unused_thread = ^thread;
  assign bus_addr = addr;
`endif

  always_ff @(posedge clk or negedge W_RST) begin
    if (!W_RST) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_enable) state_nxt = REQ;
      REQ:     if (bus_ack)  state_nxt = RESP;
      RESP:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields hold outside the IDLE launch.
  always_comb begin
    f_ack_d   = 1'b0;
    f_data_d  = f_data_o;
    w_addr_d  = W_ADDR;
    w_data_d  = W_DATA_O;
    w_write_d = W_WRITE;
    lat_we_d  = lat_we;
    case (state)
      IDLE: if (f_enable) begin
        w_addr_d  = bus_addr;
        w_data_d  = f_data_i;
        w_write_d = f_write_enable;
        lat_we_d  = f_write_enable;
      end
      REQ: if (bus_ack) begin
        f_ack_d   = 1'b1;
        w_write_d = 1'b0;
        if (!lat_we) f_data_d = W_DATA_I;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge W_RST) begin
    if (!W_RST) begin
      f_ack    <= 1'b0;
      f_data_o <= '0;
      W_ADDR   <= '0;
      W_DATA_O <= '0;
      W_WRITE  <= 1'b0;
      lat_we   <= 1'b0;
    end else begin
      f_ack    <= f_ack_d;
      f_data_o <= f_data_d;
      W_ADDR   <= w_addr_d;
      W_DATA_O <= w_data_d;
      W_WRITE  <= w_write_d;
      lat_we   <= lat_we_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table of single transactions plus hand-written corner sequences.
module tb_fetch;

  logic        clk = 1'b0;
  logic        W_RST = 1'b1;
  logic        f_enable = 1'b0, f_write_enable = 1'b0;
  logic [31:0] addr = '0, f_data_i = '0;
  logic [1:0]  thread = '0;
  logic [31:0] f_data_o;
  logic        f_ack;
  logic        W_CLK = 1'b1, W_ACK = 1'b0;
  logic [31:0] W_DATA_I = '0;
  logic [31:0] W_DATA_O, W_ADDR;
  logic        W_WRITE;

  int n_pass = 0, n_total = 0;

  fetch dut (
    .clk(clk), .W_RST(W_RST), .f_enable(f_enable), .f_write_enable(f_write_enable),
    .addr(addr), .f_data_i(f_data_i), .thread(thread), .f_data_o(f_data_o),
    .f_ack(f_ack), .W_CLK(W_CLK), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I),
    .W_DATA_O(W_DATA_O), .W_ADDR(W_ADDR), .W_WRITE(W_WRITE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  thread;
    int          ack_dly;
    logic [31:0] rdata;
    logic [31:0] exp_waddr;
    logic [31:0] exp_fdata;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    f_enable = 1'b1; f_write_enable = v.we; addr = v.addr;
    f_data_i = v.wdata; thread = v.thread; W_CLK = 1'b1; W_ACK = 1'b0;
    tick();
    chk($sformatf("v%0d W_ADDR", i), W_ADDR, v.exp_waddr);
    chk($sformatf("v%0d W_DATA_O", i), W_DATA_O, v.wdata);
    chk($sformatf("v%0d W_WRITE", i), {31'b0, W_WRITE}, {31'b0, v.we});
    // Scramble CPU inputs while REQ holds the latched request.
    f_enable = 1'b0; addr = ~v.addr; f_data_i = ~v.wdata; f_write_enable = ~v.we;
    for (int d = 0; d < v.ack_dly; d++) begin
      tick();
      chk($sformatf("v%0d hold W_ADDR", i), W_ADDR, v.exp_waddr);
      chk($sformatf("v%0d hold W_WRITE", i), {31'b0, W_WRITE}, {31'b0, v.we});
      chk($sformatf("v%0d no ack", i), {31'b0, f_ack}, 32'd0);
    end
    W_ACK = 1'b1; W_DATA_I = v.rdata;
    tick();
    W_ACK = 1'b0;
    chk($sformatf("v%0d f_ack", i), {31'b0, f_ack}, 32'd1);
    chk($sformatf("v%0d W_WRITE drop", i), {31'b0, W_WRITE}, 32'd0);
    chk($sformatf("v%0d f_data_o", i), f_data_o, v.exp_fdata);
    tick();
    chk($sformatf("v%0d f_ack pulse", i), {31'b0, f_ack}, 32'd0);
    chk($sformatf("v%0d W_ADDR idle hold", i), W_ADDR, v.exp_waddr);
  endtask

  initial begin
    vecs[0] = '{32'h10, 32'h0, 1'b0, 2'd0, 3, 32'hCAFEBABE, 32'h10, 32'hCAFEBABE};
    vecs[1] = '{32'h20, 32'h12345678, 1'b1, 2'd1, 1, 32'hDEADBEEF,
`ifdef FETCH_THREAD_BANK_EN
                32'h40000020,
`else
                32'h20,
`endif
                32'hCAFEBABE};
    vecs[2] = '{32'h100, 32'h0, 1'b0, 2'd2, 0, 32'h000000A5,
`ifdef FETCH_THREAD_BANK_EN
                32'h80000100,
`else
                32'h100,
`endif
                32'h000000A5};
    vecs[3] = '{32'hFFFFFFFC, 32'hA5A55A5A, 1'b1, 2'd3, 2, 32'h11111111, 32'hFFFFFFFC, 32'h000000A5};
    vecs[4] = '{32'hC0000004, 32'h0, 1'b0, 2'd0, 1, 32'h00000001,
`ifdef FETCH_THREAD_BANK_EN
                32'h00000004,
`else
                32'hC0000004,
`endif
                32'h00000001};

    #2 W_RST = 1'b0;
    #1;
    chk("rst f_ack", {31'b0, f_ack}, 32'd0);
    chk("rst f_data_o", f_data_o, 32'd0);
    chk("rst W_ADDR", W_ADDR, 32'd0);
    chk("rst W_DATA_O", W_DATA_O, 32'd0);
    chk("rst W_WRITE", {31'b0, W_WRITE}, 32'd0);
    #10 W_RST = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Acknowledge without W_CLK qualification is ignored.
    f_enable = 1'b1; f_write_enable = 1'b0; addr = 32'h30; thread = 2'd0;
    tick();
    f_enable = 1'b0; W_CLK = 1'b0; W_ACK = 1'b1; W_DATA_I = 32'h55;
    for (int d = 0; d < 4; d++) begin
      tick();
      chk("unqual no ack", {31'b0, f_ack}, 32'd0);
    end
    W_CLK = 1'b1;
    tick();
    W_ACK = 1'b0;
    chk("qual f_ack", {31'b0, f_ack}, 32'd1);
    chk("qual f_data_o", f_data_o, 32'h55);
    tick();
    chk("qual ack once", {31'b0, f_ack}, 32'd0);

    // Back-to-back reads with f_enable held high.
    f_enable = 1'b1; addr = 32'h4; W_ACK = 1'b1; W_DATA_I = 32'h111;
    tick();
    chk("b2b W_ADDR 1", W_ADDR, 32'h4);
    chk("b2b no ack in REQ", {31'b0, f_ack}, 32'd0);
    tick();
    chk("b2b ack 1", {31'b0, f_ack}, 32'd1);
    chk("b2b data 1", f_data_o, 32'h111);
    addr = 32'h8; W_DATA_I = 32'h222;
    tick();
    chk("b2b idle gap", {31'b0, f_ack}, 32'd0);
    chk("b2b idle W_ADDR", W_ADDR, 32'h4);
    tick();
    chk("b2b W_ADDR 2", W_ADDR, 32'h8);
    chk("b2b no ack 2", {31'b0, f_ack}, 32'd0);
    tick();
    chk("b2b ack 2", {31'b0, f_ack}, 32'd1);
    chk("b2b data 2", f_data_o, 32'h222);
    f_enable = 1'b0; W_ACK = 1'b0;
    tick();
    chk("b2b end", {31'b0, f_ack}, 32'd0);

    // Asynchronous reset mid-REQ drops the write.
    f_enable = 1'b1; f_write_enable = 1'b1; addr = 32'h40; f_data_i = 32'h77;
    tick();
    f_enable = 1'b0;
    chk("rreq W_WRITE", {31'b0, W_WRITE}, 32'd1);
    #3 W_RST = 1'b0;
    #1;
    chk("rreq W_WRITE clr", {31'b0, W_WRITE}, 32'd0);
    chk("rreq W_ADDR clr", W_ADDR, 32'd0);
    chk("rreq W_DATA_O clr", W_DATA_O, 32'd0);
    chk("rreq f_data_o clr", f_data_o, 32'd0);
    W_ACK = 1'b1;
    tick();
    chk("rreq no ack", {31'b0, f_ack}, 32'd0);
    W_ACK = 1'b0;
    f_enable = 1'b1; f_write_enable = 1'b0; addr = 32'h50;
    #3 W_RST = 1'b1;
    tick();
    chk("post rst start", W_ADDR, 32'h50);
    chk("post rst no ack", {31'b0, f_ack}, 32'd0);
    f_enable = 1'b0; W_ACK = 1'b1; W_DATA_I = 32'h9;
    tick();
    W_ACK = 1'b0;
    chk("post rst ack", {31'b0, f_ack}, 32'd1);
    chk("post rst data", f_data_o, 32'h9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
